spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Transaction controller between the byte-level SPI shift engine and the configuration/status register banks. It decodes the command byte of each chip-select frame, sequences reads and writes with optional address auto-increment, and owns the configuration register storage. It sits downstream of the input synchronizers and replaces the ad-hoc register access inside the SPI wrapper.

## Interface
Parameters:
- NUM_CFG, 8, number of configuration registers (1..64)
- NUM_STATUS, 8, number of status registers (1..64)
- REG_WIDTH, 8, register width; fixed at 8 (one byte per SPI data phase)

Ports:
- clk  in  1  system clock; the block's one clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  clock enable; when 0, all state and outputs hold
- spi_cs_n  in  1  synchronized chip select, active-low
- rx_valid  in  1  one-cycle pulse: complete byte received from the shift engine
- rx_data  in  8  received byte, valid with rx_valid
- tx_data  out  8  byte the shift engine sends in the next byte slot
- tx_valid  out  1  tx_data holds read data for the current frame
- config_regs  out  NUM_CFG*REG_WIDTH  flat config bank, register i at [8i+7:8i]
- status_regs  in  NUM_STATUS*REG_WIDTH  flat status bank, same packing
- cfg_wr_stb  out  NUM_CFG  one-cycle pulse per written config register
- err  out  1  sticky frame error flag

## Operation
- Command byte: bit7 = 1 write / 0 read; bit6 = 1 status space / 0 config space; bits[5:0] = index.
- FSM states: IDLE, CMD, DATA, DROP.
- IDLE: spi_cs_n = 1. spi_cs_n = 0 moves to CMD and clears err.
- CMD: rx_valid latches the command and the address, then moves to DATA.
  - Read: tx_data is loaded with the addressed register and tx_valid is set.
  - Illegal command: moves to DROP instead, sets err, and leaves tx_data = 0x00.
- Illegal commands:
  - write with bit6 = 1
  - config index >= NUM_CFG
  - status index >= NUM_STATUS
- DATA, write: each rx_valid stores rx_data into config[addr] and pulses cfg_wr_stb[addr].
- DATA, read: each rx_valid advances the address and reloads tx_data. The received byte is ignored.
- Address advance: addr+1, wrapping to 0 at the bank size (NUM_CFG or NUM_STATUS).
- DROP: all rx_valid are ignored and no writes occur.
- spi_cs_n = 1 in any state returns to IDLE and clears tx_valid. A partial byte produces no rx_valid, so nothing is committed.
- Simultaneous spi_cs_n = 1 and rx_valid: chip-select wins and the byte is discarded.

## Timing
- Reset values:
  - state IDLE
  - config_regs all 0
  - tx_data 0x00
  - tx_valid 0
  - cfg_wr_stb 0
  - err 0
- config write: config_regs updates on the clk edge that samples rx_valid. cfg_wr_stb is high for exactly that following cycle.
- Read latency: tx_data/tx_valid are valid 1 clk after the rx_valid of the command or data byte.
- tx_data is a registered snapshot. A status change after the load does not alter tx_data.
- err: set 1 clk after the illegal rx_valid. Held until the next spi_cs_n falling edge (sampled) or reset.
- Reset mid-frame: immediate return to reset values. The frame resumes only after a fresh spi_cs_n falling edge.
- ena = 0: no register updates, and any rx_valid pulse during that time is lost.

## Configuration
- SPI_REG_CTRL_BURST_EN defined: DATA accepts unlimited bytes with address auto-increment and wrap.
- Not defined: after the first data byte the FSM enters DROP.
  - Further bytes in the frame are ignored. err is not set.
  - tx_valid clears after the first data byte of a read.

## Structure
- Shared package spi_reg_pkg holds:
  - FSM state enum
  - command bit positions CMD_WR_BIT = 7, CMD_STS_BIT = 6
  - CMD_IDX_W = 6
  - idx width function clog2-based
- Sub-module spi_reg_bank holds config storage:
  - inputs: write enable, index, data
  - outputs: flat config_regs, cfg_wr_stb
  - the FSM, address counter, tx mux and err remain in spi_reg_ctrl

## Test plan
- Write burst (BURST_EN): cs low, bytes 0x82, 0x11, 0x22 → config[2] = 0x11, config[3] = 0x22, stb pulses bit2 then bit3; config[0] unchanged.
- Read status with wrap (BURST_EN, NUM_STATUS = 8, status = CA,10,AA,55,FF,00,A5,5A): cmd 0x47, dummy, dummy → tx_data 0x5A, then 0xCA, then 0x10.
- Illegal access: cmd 0xC0 → err = 1, no cfg_wr_stb, tx_data 0x00; next cs falling edge clears err. Cmd 0x09 with NUM_CFG = 8 → err = 1.
- Non-burst: cmd 0x81, bytes 0x33, 0x44 → config[1] = 0x33, config[2] unchanged, err = 0.
- Abort: cs rises in the same cycle as rx_valid of a data byte → no write, FSM IDLE, tx_valid 0.
- Async reset mid-write frame → all config 0 immediately; a following frame without a new cs falling edge is ignored.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and command-byte layout for the SPI register controller.
// Burst auto-increment is enabled by defining SPI_REG_CTRL_BURST_EN.
package spi_reg_pkg;

    typedef enum logic [1:0] {StIdle, StCmd, StData, StDrop} state_e;

    localparam int unsigned CMD_WR_BIT  = 7;
    localparam int unsigned CMD_STS_BIT = 6;
    localparam int unsigned CMD_IDX_W   = 6;

    // Index width for a bank of n registers; a single-entry bank still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// Configuration register storage with per-register write strobes.
// Holds all state while ena is low.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_CFG   = 8,
    parameter int unsigned REG_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic                           wr_en,
    input  logic [idx_w(NUM_CFG)-1:0]      wr_idx,
    input  logic [REG_WIDTH-1:0]           wr_data,
    output logic [NUM_CFG*REG_WIDTH-1:0]   config_regs,
    output logic [NUM_CFG-1:0]             cfg_wr_stb
);

    localparam int unsigned IdxW = idx_w(NUM_CFG);

    logic [REG_WIDTH-1:0] regs_q [NUM_CFG];
    logic [REG_WIDTH-1:0] regs_d [NUM_CFG];
    logic [NUM_CFG-1:0]   stb_q, stb_d;

    always_comb begin
        regs_d = regs_q;
        stb_d  = '0;
        for (int unsigned i = 0; i < NUM_CFG; i++) begin
            if (wr_en && (wr_idx == IdxW'(i))) begin
                regs_d[i] = wr_data;
                stb_d[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            stb_q  <= '0;
        end else if (ena) begin
            regs_q <= regs_d;
            stb_q  <= stb_d;
        end
    end

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_flat
        assign config_regs[i*REG_WIDTH +: REG_WIDTH] = regs_q[i];
    end

    assign cfg_wr_stb = stb_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame decoder: command byte, read/write sequencing, sticky frame error.
// Define SPI_REG_CTRL_BURST_EN for unlimited data bytes with address auto-increment.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_CFG    = 8,
    parameter int unsigned NUM_STATUS = 8,
    parameter int unsigned REG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ena,
    input  logic                            spi_cs_n,
    input  logic                            rx_valid,
    input  logic [REG_WIDTH-1:0]            rx_data,
    output logic [REG_WIDTH-1:0]            tx_data,
    output logic                            tx_valid,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic [NUM_CFG-1:0]              cfg_wr_stb,
    output logic                            err
);

`ifdef SPI_REG_CTRL_BURST_EN
    localparam bit BurstEn = 1'b1;
`else
    localparam bit BurstEn = 1'b0;
`endif

    localparam int unsigned CfgIdxW = idx_w(NUM_CFG);
    localparam int unsigned StsIdxW = idx_w(NUM_STATUS);

    state_e state_q, state_d;
    logic [CMD_IDX_W-1:0] addr_q, addr_d;
    logic                 is_wr_q, is_wr_d;
    logic                 is_sts_q, is_sts_d;
    logic [REG_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 err_q, err_d;
    logic                 cs_prev_q;
    logic                 bank_we;

    logic [REG_WIDTH-1:0] cfg_arr [NUM_CFG];
    logic [REG_WIDTH-1:0] sts_arr [NUM_STATUS];

    for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
        assign cfg_arr[i] = config_regs[i*REG_WIDTH +: REG_WIDTH];
    end
    for (genvar i = 0; i < NUM_STATUS; i++) begin : g_sts
        assign sts_arr[i] = status_regs[i*REG_WIDTH +: REG_WIDTH];
    end

    // cs_prev_q resets low so a chip select already asserted across reset is not a new frame.
    logic cs_fall, rx;
    assign cs_fall = cs_prev_q && !spi_cs_n;
    assign rx      = rx_valid && !spi_cs_n;

    logic                 cmd_wr, cmd_sts, cmd_ok;
    logic [CMD_IDX_W-1:0] cmd_idx;
    assign cmd_wr  = rx_data[CMD_WR_BIT];
    assign cmd_sts = rx_data[CMD_STS_BIT];
    assign cmd_idx = rx_data[CMD_IDX_W-1:0];
    assign cmd_ok  = cmd_sts ? (!cmd_wr && (32'(cmd_idx) < NUM_STATUS))
                             : (32'(cmd_idx) < NUM_CFG);

    logic [CMD_IDX_W-1:0] bank_last, addr_next;
    assign bank_last = is_sts_q ? CMD_IDX_W'(NUM_STATUS - 1) : CMD_IDX_W'(NUM_CFG - 1);
    assign addr_next = (addr_q == bank_last) ? '0 : addr_q + 1'b1;

    logic [REG_WIDTH-1:0] cmd_byte, next_byte;
    assign cmd_byte  = cmd_sts ? sts_arr[cmd_idx[StsIdxW-1:0]] : cfg_arr[cmd_idx[CfgIdxW-1:0]];
    assign next_byte = is_sts_q ? sts_arr[addr_next[StsIdxW-1:0]]
                                : cfg_arr[addr_next[CfgIdxW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (cs_fall) state_d = StCmd;
            StCmd: begin
                if (spi_cs_n)      state_d = StIdle;
                else if (rx_valid) state_d = cmd_ok ? StData : StDrop;
            end
            StData: begin
                if (spi_cs_n)                 state_d = StIdle;
                else if (rx_valid && !BurstEn) state_d = StDrop;
            end
            StDrop: if (spi_cs_n) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        is_wr_d    = is_wr_q;
        is_sts_d   = is_sts_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = err_q;
        bank_we    = 1'b0;
        case (state_q)
            StIdle: if (cs_fall) err_d = 1'b0;
            StCmd: begin
                if (rx) begin
                    is_wr_d  = cmd_wr;
                    is_sts_d = cmd_sts;
                    addr_d   = cmd_idx;
                    if (cmd_ok) begin
                        tx_data_d  = cmd_wr ? '0 : cmd_byte;
                        tx_valid_d = !cmd_wr;
                    end else begin
                        err_d      = 1'b1;
                        tx_data_d  = '0;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (rx) begin
                    bank_we = is_wr_q;
                    if (BurstEn) begin
                        addr_d = addr_next;
                        if (!is_wr_q) tx_data_d = next_byte;
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if (spi_cs_n) tx_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            is_sts_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            cs_prev_q  <= 1'b0;
        end else if (ena) begin
            addr_q     <= addr_d;
            is_wr_q    <= is_wr_d;
            is_sts_q   <= is_sts_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            cs_prev_q  <= spi_cs_n;
        end
    end

    spi_reg_bank #(
        .NUM_CFG   (NUM_CFG),
        .REG_WIDTH (REG_WIDTH)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .wr_en       (bank_we),
        .wr_idx      (addr_q[CfgIdxW-1:0]),
        .wr_data     (rx_data),
        .config_regs (config_regs),
        .cfg_wr_stb  (cfg_wr_stb)
    );

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed scoreboard bench for spi_reg_ctrl (8 config / 8 status registers).
module tb_spi_reg_ctrl;

`ifdef SPI_REG_CTRL_BURST_EN
    localparam bit Burst = 1'b1;
`else
    localparam bit Burst = 1'b0;
`endif

    localparam int SelTx  = 0;
    localparam int SelVal = 1;
    localparam int SelStb = 2;
    localparam int SelErr = 3;
    localparam int SelCfg = 4;

    logic        clk = 1'b0;
    logic        rst_n, ena, spi_cs_n, rx_valid;
    logic [7:0]  rx_data, tx_data, cfg_wr_stb;
    logic        tx_valid, err;
    logic [63:0] config_regs, status_regs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    logic [7:0] cfg_m [8];

    spi_reg_ctrl #(
        .NUM_CFG    (8),
        .NUM_STATUS (8),
        .REG_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .spi_cs_n    (spi_cs_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .cfg_wr_stb  (cfg_wr_stb),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cfg_flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = cfg_m[i];
        return r;
    endfunction

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            SelTx:   return {56'h0, tx_data};
            SelVal:  return {63'h0, tx_valid};
            SelStb:  return {56'h0, cfg_wr_stb};
            SelErr:  return {63'h0, err};
            default: return config_regs;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, pick(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        tick();
    endtask

    task automatic cs_end();
        spi_cs_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        status_regs = 64'h5AA5_00FF_55AA_10CA;
        for (int i = 0; i < 8; i++) cfg_m[i] = 8'h00;
        #12;
        push("rst_cfg", SelCfg, 64'h0); push("rst_tx", SelTx, 64'h0);
        push("rst_val", SelVal, 64'h0); push("rst_stb", SelStb, 64'h0);
        push("rst_err", SelErr, 64'h0);
        drain();
        rst_n = 1'b1;
        tick(); tick();

        // Write burst starting at config[2]
        cs_start();
        push("wr_cmd_stb", SelStb, 64'h0);
        send(8'h82); drain();
        cfg_m[2] = 8'h11;
        push("wr_d0_stb", SelStb, 64'h04); push("wr_d0_cfg", SelCfg, cfg_flat());
        send(8'h11); drain();
        if (Burst) cfg_m[3] = 8'h22;
        push("wr_d1_stb", SelStb, Burst ? 64'h08 : 64'h00); push("wr_d1_cfg", SelCfg, cfg_flat());
        send(8'h22); drain();
        check("wr_cfg0_untouched", {56'h0, config_regs[7:0]}, 64'h0);
        cs_end();

        // Status read from index 7, wrapping to 0
        cs_start();
        push("rd_cmd_tx", SelTx, 64'h5A); push("rd_cmd_val", SelVal, 64'h1);
        send(8'h47); drain();
        status_regs[63:56] = 8'h00;
        tick();
        push("rd_snapshot", SelTx, 64'h5A); drain();
        status_regs[63:56] = 8'h5A;
        push("rd_d0_tx", SelTx, Burst ? 64'hCA : 64'h5A); push("rd_d0_val", SelVal, {63'h0, Burst});
        send(8'h00); drain();
        push("rd_d1_tx", SelTx, Burst ? 64'h10 : 64'h5A);
        send(8'h00); drain();
        cs_end();
        push("rd_cs_val", SelVal, 64'h0); drain();

        // Illegal commands
        cs_start();
        push("ill_wr_sts_err", SelErr, 64'h1); push("ill_wr_sts_tx", SelTx, 64'h0);
        push("ill_wr_sts_val", SelVal, 64'h0); push("ill_wr_sts_stb", SelStb, 64'h0);
        send(8'hC0); drain();
        push("ill_drop_stb", SelStb, 64'h0); push("ill_drop_cfg", SelCfg, cfg_flat());
        send(8'h55); drain();
        cs_end();
        push("ill_err_held", SelErr, 64'h1); drain();
        cs_start();
        push("ill_err_clr", SelErr, 64'h0); drain();
        push("ill_idx_err", SelErr, 64'h1);
        send(8'h09); drain();
        cs_end();

        // Write to config[1]; second byte lands in config[2] only in burst builds
        cs_start();
        send(8'h81);
        cfg_m[1] = 8'h33;
        push("nb_d0_stb", SelStb, 64'h02); push("nb_d0_cfg", SelCfg, cfg_flat());
        send(8'h33); drain();
        if (Burst) cfg_m[2] = 8'h44;
        push("nb_d1_cfg", SelCfg, cfg_flat()); push("nb_err", SelErr, 64'h0);
        send(8'h44); drain();
        cs_end();

        // A byte arriving while ena is low is lost
        cs_start();
        send(8'h84);
        ena = 1'b0; rx_valid = 1'b1; rx_data = 8'h66;
        tick();
        rx_valid = 1'b0; ena = 1'b1;
        tick();
        push("ena_lost_stb", SelStb, 64'h0); push("ena_lost_cfg", SelCfg, cfg_flat());
        drain();
        cfg_m[4] = 8'h67;
        push("ena_wr_stb", SelStb, 64'h10); push("ena_wr_cfg", SelCfg, cfg_flat());
        send(8'h67); drain();
        cs_end();

        // Chip select rising together with a data byte discards it
        cs_start();
        send(8'h85);
        rx_valid = 1'b1; rx_data = 8'h77; spi_cs_n = 1'b1;
        tick();
        rx_valid = 1'b0;
        push("abort_stb", SelStb, 64'h0); push("abort_cfg", SelCfg, cfg_flat());
        drain();
        tick();
        cs_start();
        push("abort_rd_val", SelVal, 64'h1);
        send(8'h40); drain();
        rx_valid = 1'b1; rx_data = 8'h00; spi_cs_n = 1'b1;
        tick();
        rx_valid = 1'b0;
        push("abort_rd_clr", SelVal, 64'h0); drain();
        tick();

        // Asynchronous reset in the middle of a write frame
        cs_start();
        send(8'h80);
        cfg_m[0] = 8'h99;
        push("pre_rst_cfg", SelCfg, cfg_flat());
        send(8'h99); drain();
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) cfg_m[i] = 8'h00;
        push("async_rst_cfg", SelCfg, 64'h0); push("async_rst_stb", SelStb, 64'h0);
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send(8'h80);
        push("post_rst_stb", SelStb, 64'h0); push("post_rst_cfg", SelCfg, 64'h0);
        send(8'hEE); drain();
        cs_end();
        cs_start();
        send(8'h80);
        cfg_m[0] = 8'h5C;
        push("resume_cfg", SelCfg, cfg_flat()); push("resume_stb", SelStb, 64'h01);
        send(8'h5C); drain();
        cs_end();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
